// File: rtl/count_sched_pkg.sv
// Shared types and constants for the round-robin scheduled interval timer.
package count_sched_pkg;

    localparam int WIDTH   = 7;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/count_sched_if.sv
// Request/completion bundle between the timer and its two requesters.
// The abort signal exists only when COUNT_SCHED_ABORT_EN is defined.
interface count_sched_if;
    import count_sched_pkg::*;

    logic [NUM_REQ-1:0] req_valid;
    logic [WIDTH-1:0]   req_len0;
    logic [WIDTH-1:0]   req_len1;
    logic [NUM_REQ-1:0] req_ready;
`ifdef COUNT_SCHED_ABORT_EN
    logic               abort;
`endif
    logic               busy;
    logic               grant_id;
    logic [WIDTH-1:0]   cnt_q;
    logic               done;
    logic               done_id;
    logic               done_abort;

`ifdef COUNT_SCHED_ABORT_EN
    modport master (output req_valid, req_len0, req_len1, abort,
                    input  req_ready, busy, grant_id, cnt_q, done, done_id, done_abort);
    modport slave  (input  req_valid, req_len0, req_len1, abort,
                    output req_ready, busy, grant_id, cnt_q, done, done_id, done_abort);
`else
    modport master (output req_valid, req_len0, req_len1,
                    input  req_ready, busy, grant_id, cnt_q, done, done_id, done_abort);
    modport slave  (input  req_valid, req_len0, req_len1,
                    output req_ready, busy, grant_id, cnt_q, done, done_id, done_abort);
`endif

endinterface

// File: rtl/count_sched_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester not
// granted last wins; a lone requester always wins.
module rr_pick2
    import count_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic               rr_last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               id_o
);

    always_comb begin
        id_o    = 1'b0;
        grant_o = '0;
        case (req_valid_i)
            2'b01:   id_o = 1'b0;
            2'b10:   id_o = 1'b1;
            2'b11:   id_o = ~rr_last_i;
            default: id_o = 1'b0;
        endcase
        if (|req_valid_i)
            grant_o[id_o] = 1'b1;
    end

endmodule

// File: rtl/count_sched.sv
// Round-robin scheduled interval timer sharing one 7-bit up-counter.
// Optional run cancellation is enabled by COUNT_SCHED_ABORT_EN.
module count_sched
    import count_sched_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    count_sched_if.slave bus
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d, len_q, len_d, sel_len, cnt_inc;
    logic               grant_q, grant_d, rr_last_q, rr_last_d;
    logic               abort_q, abort_d, abort_in;
    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_id;

`ifdef COUNT_SCHED_ABORT_EN
    assign abort_in = bus.abort;
`else
    assign abort_in = 1'b0;
`endif

    rr_pick2 u_pick (
        .req_valid_i (bus.req_valid),
        .rr_last_i   (rr_last_q),
        .grant_o     (pick_grant),
        .id_o        (pick_id)
    );

    assign sel_len = pick_id ? bus.req_len1 : bus.req_len0;
    assign cnt_inc = cnt_q + WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        abort_d   = abort_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    len_d   = sel_len;
                    cnt_d   = '0;
                    grant_d = pick_id;
                    abort_d = 1'b0;
                    state_d = (sel_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Abort wins over the increment so the count freezes where it stood.
                if (abort_in) begin
                    abort_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q)
                        state_d = DONE;
                end
            end
            DONE: begin
                rr_last_d = grant_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            grant_q   <= 1'b0;
            rr_last_q <= 1'b1;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            abort_q   <= abort_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE && !rst_i) ? pick_grant : '0;
    assign bus.busy       = (state_q != IDLE);
    assign bus.grant_id   = grant_q;
    assign bus.cnt_q      = cnt_q;
    assign bus.done       = (state_q == DONE);
    assign bus.done_id    = (state_q == DONE) & grant_q;
    assign bus.done_abort = (state_q == DONE) & abort_q;

endmodule

// File: tb/tb_count_sched.sv
// Self-checking bench for count_sched: elapsed-time job model plus directed
// literal checks; abort scenarios compile in with COUNT_SCHED_ABORT_EN.
module tb_count_sched;
    import count_sched_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic ab;
    always #5 clk = ~clk;

    count_sched_if bus ();
`ifdef COUNT_SCHED_ABORT_EN
    assign bus.abort = ab;
`endif

    count_sched dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Job model: a run is described by elapsed cycles since its accept edge.
    bit m_active = 0, m_ab = 0, m_id = 0, m_last_id = 1;
    int m_len, m_k, m_done_at, m_done_cnt, m_last_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit winner(input logic [1:0] v);
        if (v == 2'b11) return !m_last_id;
        return v[1];
    endfunction

    function automatic bit ab_eff();
`ifdef COUNT_SCHED_ABORT_EN
        return ab;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_update();
        if (rst) begin
            m_active = 0; m_last_id = 1; m_last_cnt = 0;
        end else if (!m_active) begin
            if (|bus.req_valid) begin
                m_id = winner(bus.req_valid);
                m_len = m_id ? int'(bus.req_len1) : int'(bus.req_len0);
                m_active = 1; m_k = 1; m_ab = 0;
                m_done_at = m_len + 1; m_done_cnt = m_len;
            end
        end else if (m_k == m_done_at) begin
            m_active = 0; m_last_id = m_id; m_last_cnt = m_done_cnt;
        end else begin
            if (ab_eff()) begin
                m_done_at = m_k + 1; m_done_cnt = m_k - 1; m_ab = 1;
            end
            m_k++;
        end
    endtask

    task automatic compare();
        int e_rdy, e_busy, e_cnt, e_done, e_did, e_dab;
        e_rdy = 0; e_busy = 0; e_done = 0; e_did = 0; e_dab = 0; e_cnt = m_last_cnt;
        if (m_active) begin
            e_busy = 1;
            if (m_k < m_done_at) e_cnt = m_k - 1;
            else begin
                e_done = 1; e_did = m_id; e_dab = m_ab; e_cnt = m_done_cnt;
            end
            chk("grant_id", bus.grant_id, m_id);
        end else if (!rst && |bus.req_valid) begin
            e_rdy = winner(bus.req_valid) ? 2 : 1;
        end
        chk("req_ready", bus.req_ready, e_rdy);
        chk("busy", bus.busy, e_busy);
        chk("cnt_q", bus.cnt_q, e_cnt);
        chk("done", bus.done, e_done);
        chk("done_id", bus.done_id, e_did);
        chk("done_abort", bus.done_abort, e_dab);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (chk_en) compare();
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        bus.req_valid = 2'b00; ab = 0;
        while (bus.busy && n < 300) begin tick(); n++; end
        chk("idle_timeout", int'(bus.busy), 0);
    endtask

    initial begin
        int dids[$];
        int dts[$];
        int n;
        rst = 1; ab = 0;
        bus.req_valid = 2'b00; bus.req_len0 = '0; bus.req_len1 = '0;
        tick();
        chk_en = 1;
        tick(); rst = 0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_cnt", bus.cnt_q, 0);
        chk("rst_grant", bus.grant_id, 0);

        // Single requester, len 5.
        bus.req_valid = 2'b01; bus.req_len0 = 7'd5; #1;
        chk("t1_ready", bus.req_ready, 1);
        tick(); bus.req_valid = 2'b00; bus.req_len0 = 7'd99;
        chk("t1_cnt_k1", bus.cnt_q, 0);
        repeat (4) tick();
        chk("t1_cnt_k5", bus.cnt_q, 4);
        tick();
        chk("t1_done", bus.done, 1);
        chk("t1_done_id", bus.done_id, 0);
        chk("t1_done_cnt", bus.cnt_q, 5);
        tick();
        chk("t1_busy_fall", bus.busy, 0);
        chk("t1_done_single", bus.done, 0);

        // Both valid: alternation and len+2 spacing.
        do_reset();
        bus.req_valid = 2'b11; bus.req_len0 = 7'd3; bus.req_len1 = 7'd2;
        n = 0;
        while (dids.size() < 4 && n < 100) begin
            tick(); n++;
            if (bus.done) begin dids.push_back(bus.done_id); dts.push_back(n); end
        end
        chk("t2_ndone", dids.size(), 4);
        if (dids.size() == 4) begin
            chk("t2_id0", dids[0], 0); chk("t2_id1", dids[1], 1);
            chk("t2_id2", dids[2], 0); chk("t2_id3", dids[3], 1);
            chk("t2_gap01", dts[1] - dts[0], 4);
            chk("t2_gap12", dts[2] - dts[1], 5);
            chk("t2_gap23", dts[3] - dts[2], 4);
        end
        wait_idle();

        // Zero-length run.
        bus.req_valid = 2'b10; bus.req_len1 = 7'd0;
        tick(); bus.req_valid = 2'b00;
        chk("t3_done", bus.done, 1);
        chk("t3_done_id", bus.done_id, 1);
        chk("t3_cnt", bus.cnt_q, 0);
        tick();

        // Reset in the middle of a long run.
        do_reset();
        bus.req_valid = 2'b01; bus.req_len0 = 7'd100;
        tick(); bus.req_valid = 2'b00;
        repeat (40) tick();
        chk("t4_cnt40", bus.cnt_q, 40);
        rst = 1; tick();
        chk("t4_cnt", bus.cnt_q, 0);
        chk("t4_busy", bus.busy, 0);
        chk("t4_done", bus.done, 0);
        rst = 0; bus.req_valid = 2'b11; #1;
        chk("t4_ready", bus.req_ready, 1);
        tick();
        chk("t4_grant", bus.grant_id, 0);
        wait_idle();

        // Longest run.
        bus.req_valid = 2'b01; bus.req_len0 = 7'd127;
        tick(); bus.req_valid = 2'b00;
        repeat (127) tick();
        chk("t5_done", bus.done, 1);
        chk("t5_cnt", bus.cnt_q, 127);
        chk("t5_abort", bus.done_abort, 0);
        tick();

`ifdef COUNT_SCHED_ABORT_EN
        bus.req_valid = 2'b01; bus.req_len0 = 7'd50;
        tick(); bus.req_valid = 2'b00;
        repeat (10) tick();
        chk("t6_cnt10", bus.cnt_q, 10);
        ab = 1; tick(); ab = 0;
        chk("t6_done", bus.done, 1);
        chk("t6_abort", bus.done_abort, 1);
        chk("t6_cnt", bus.cnt_q, 10);
        tick();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.req_valid = 2'($urandom_range(0, 3));
            bus.req_len0 = ($urandom_range(0, 15) == 0) ? 7'($urandom) : 7'($urandom_range(0, 8));
            bus.req_len1 = ($urandom_range(0, 15) == 0) ? 7'($urandom) : 7'($urandom_range(0, 8));
            ab  = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 0; ab = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
